// File: rtl/sao_param_filter.sv
// SAO filter: buffers one LCU in raster order, applies band or edge offset, streams it to a frame SRAM.
// Writes start one cycle after the last pixel of an LCU; busy holds off input for the N*N drain cycles.
module sao_param_filter #(
    parameter int BIT_DEPTH = 8,
    parameter int OFF_W     = 4,
    parameter int IMG_W     = 128,
    parameter int IMG_H     = 128,
    localparam int CW = $clog2(IMG_W / 16),
    localparam int AW = $clog2(IMG_W * IMG_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_en,
    input  logic [BIT_DEPTH-1:0]   din,
    input  logic [1:0]             sao_type,
    input  logic [4:0]             sao_band_pos,
    input  logic                   sao_eo_class,
    input  logic [4*OFF_W-1:0]     sao_offset,
    input  logic [CW-1:0]          lcu_x,
    input  logic [CW-1:0]          lcu_y,
    input  logic [1:0]             lcu_size,
    output logic                   busy,
    output logic                   finish,
    output logic                   sram_wen,
    output logic [AW-1:0]          sram_addr,
    output logic [BIT_DEPTH-1:0]   sram_d
);
    localparam int DW = BIT_DEPTH + 2;
    localparam logic [BIT_DEPTH-1:0] PMAX = '1;

    typedef enum logic [1:0] {LOAD, PROC, DONE} state_t;
    state_t state, state_nxt;

    logic [BIT_DEPTH-1:0] buffer [0:4095];
    logic [11:0]          cnt;
    logic [1:0]           h_type;
    logic [4:0]           h_band;
    logic                 h_class;
    logic [4*OFF_W-1:0]   h_off;
    logic [CW-1:0]        h_x, h_y;
    logic [2:0]           h_lg;

    logic        accept, cnt_last, last_lcu, on_edge, apply;
    logic [2:0]  in_lg, cur_lg;
    logic [12:0] nn;
    logic [11:0] nmask, row, col, idx_a, idx_b;
    logic [BIT_DEPTH-1:0] pc, pa, pb, pix_out;
    logic [4:0]  band, k;
    logic [1:0]  sel;
    logic [OFF_W-1:0] off_sel;
    logic [DW-1:0]    off_ext, sum;
    logic [AW-1:0]    ypix, xpix, addr_c;

    assign busy   = (state == PROC);
    assign accept = in_en && (state != PROC);

    // The first pixel of an LCU uses the live size input; everything after uses the held copy.
    assign in_lg    = (lcu_size == 2'd0) ? 3'd4 : (lcu_size == 2'd1) ? 3'd5 : 3'd6;
    assign cur_lg   = (cnt == '0 && state != PROC) ? in_lg : h_lg;
    assign nn       = 13'd1 << {cur_lg, 1'b0};
    assign cnt_last = ({1'b0, cnt} == nn - 13'd1);

    assign nmask = (12'd1 << h_lg) - 12'd1;
    assign col   = cnt & nmask;
    assign row   = cnt >> h_lg;
    assign idx_a = h_class ? cnt - (12'd1 << h_lg) : cnt - 12'd1;
    assign idx_b = h_class ? cnt + (12'd1 << h_lg) : cnt + 12'd1;
    assign pc    = buffer[cnt];
    assign pa    = buffer[idx_a];
    assign pb    = buffer[idx_b];

    assign on_edge = h_class ? (row == 12'd0 || row == nmask) : (col == 12'd0 || col == nmask);
    assign band    = pc[BIT_DEPTH-1 -: 5];
    assign k       = band - h_band;

    always_comb begin
        apply = 1'b0;
        sel   = 2'd0;
        case (h_type)
            2'd1: begin
                if (k < 5'd4) begin
                    apply = 1'b1;
                    sel   = k[1:0];
                end
            end
            2'd2: begin
                if (!on_edge) begin
                    apply = 1'b1;
                    if (pc < pa && pc < pb)                                   sel = 2'd0;
                    else if ((pc < pa && pc == pb) || (pc == pa && pc < pb))  sel = 2'd1;
                    else if ((pc > pa && pc == pb) || (pc == pa && pc > pb))  sel = 2'd2;
                    else if (pc > pa && pc > pb)                              sel = 2'd3;
                    else                                                      apply = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign off_sel = h_off[sel*OFF_W +: OFF_W];
    assign off_ext = {{(DW-OFF_W){off_sel[OFF_W-1]}}, off_sel};
    assign sum     = {2'b00, pc} + off_ext;
    // Top bit of the widened sum is the sign, the next one flags overflow past full scale.
    assign pix_out = !apply     ? pc :
                     sum[DW-1]  ? '0 :
                     sum[DW-2]  ? PMAX : sum[BIT_DEPTH-1:0];

    assign ypix   = (AW'(h_y) << h_lg) + AW'(row);
    assign xpix   = (AW'(h_x) << h_lg) + AW'(col);
    assign addr_c = ypix * AW'(IMG_W) + xpix;

    assign last_lcu = (h_x == CW'((IMG_W >> h_lg) - 1)) && (h_y == CW'((IMG_H >> h_lg) - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD, DONE: if (accept) state_nxt = cnt_last ? PROC : LOAD;
            PROC:       if (cnt_last) state_nxt = last_lcu ? DONE : LOAD;
            default:    state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) buffer[cnt] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            finish    <= 1'b0;
            sram_wen  <= 1'b0;
            sram_addr <= '0;
            sram_d    <= '0;
            h_type    <= '0;
            h_band    <= '0;
            h_class   <= 1'b0;
            h_off     <= '0;
            h_x       <= '0;
            h_y       <= '0;
            h_lg      <= 3'd4;
        end else begin
            sram_wen <= 1'b0;
            if (accept) begin
                finish <= 1'b0;
                if (cnt == '0) begin
                    h_type  <= sao_type;
                    h_band  <= sao_band_pos;
                    h_class <= sao_eo_class;
                    h_off   <= sao_offset;
                    h_x     <= lcu_x;
                    h_y     <= lcu_y;
                    h_lg    <= in_lg;
                end
                cnt <= cnt_last ? '0 : cnt + 12'd1;
            end else if (state == PROC) begin
                sram_wen  <= 1'b1;
                sram_addr <= addr_c;
                sram_d    <= pix_out;
                cnt       <= cnt_last ? '0 : cnt + 12'd1;
            end else if (state == DONE) begin
                finish <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sao_param_filter.sv
// Directed bench for sao_param_filter: BO/EO values, clipping, handshake, full frame, reset abort.
module tb_sao_param_filter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  sao_type;
    logic [4:0]  sao_band_pos;
    logic        sao_eo_class;
    logic [15:0] sao_offset;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        busy, finish, sram_wen;
    logic [13:0] sram_addr;
    logic [7:0]  sram_d;

    sao_param_filter #(.BIT_DEPTH(8), .OFF_W(4), .IMG_W(128), .IMG_H(128)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .din(din), .sao_type(sao_type),
        .sao_band_pos(sao_band_pos), .sao_eo_class(sao_eo_class), .sao_offset(sao_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .busy(busy), .finish(finish),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d)
    );

    // 10-bit instance on a 64x64 frame for the wide clipping case
    logic        t_en;
    logic [9:0]  t_din;
    logic [1:0]  t_x, t_y;
    logic        t_busy, t_finish, t_wen;
    logic [11:0] t_addr;
    logic [9:0]  t_d;

    sao_param_filter #(.BIT_DEPTH(10), .OFF_W(4), .IMG_W(64), .IMG_H(64)) dut10 (
        .clk(clk), .reset(reset), .in_en(t_en), .din(t_din), .sao_type(2'd1),
        .sao_band_pos(5'd29), .sao_eo_class(1'b0), .sao_offset(16'h87E3),
        .lcu_x(t_x), .lcu_y(t_y), .lcu_size(2'd0), .busy(t_busy), .finish(t_finish),
        .sram_wen(t_wen), .sram_addr(t_addr), .sram_d(t_d)
    );

    int total = 0;
    int bad   = 0;
    int wr_total = 0;
    int addr_log [32768];
    int dat_log  [32768];
    int t_wr = 0;
    int t_log [256];
    int pix [4096];

    always @(negedge clk) begin
        if (sram_wen) begin
            if (wr_total < 32768) begin
                addr_log[wr_total] = int'(sram_addr);
                dat_log[wr_total]  = int'(sram_d);
            end
            wr_total++;
        end
        if (t_wen) begin
            if (t_wr < 256) t_log[t_wr] = int'(t_d);
            t_wr++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send_lcu(input int n, input int typ, input int band, input int cls,
                            input int off, input int lx, input int ly, input int lsz,
                            input bit hold, input int stop_after, output int bcyc);
        sao_type     = 2'(typ);
        sao_band_pos = 5'(band);
        sao_eo_class = 1'(cls);
        sao_offset   = 16'(off);
        lcu_x        = 3'(lx);
        lcu_y        = 3'(ly);
        lcu_size     = 2'(lsz);
        for (int i = 0; i < n * n; i++) begin
            in_en = 1'b1;
            din   = 8'(pix[i]);
            @(posedge clk); #1;
            if (i == 0) begin
                sao_type     = ~sao_type;
                sao_band_pos = ~sao_band_pos;
                sao_eo_class = ~sao_eo_class;
                sao_offset   = ~sao_offset;
                lcu_x        = ~lcu_x;
                lcu_y        = ~lcu_y;
                lcu_size     = lcu_size ^ 2'd1;
            end
        end
        bcyc = 0;
        if (hold) din = 8'hFF;
        else      in_en = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (!busy) break;
            bcyc++;
            if (stop_after != 0 && bcyc == stop_after) break;
        end
        in_en = 1'b0;
        if (stop_after == 0) check("idle", int'(busy), 0);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 4096; i++) pix[i] = v;
    endtask

    int bc, base, fbase, n0, errs, uniq, a, e;
    int bo_exp [5] = '{243, 248, 7, 2, 100};
    bit seen [16384];

    initial begin
        reset = 1'b0; in_en = 1'b0; din = '0; sao_type = '0; sao_band_pos = '0;
        sao_eo_class = 1'b0; sao_offset = '0; lcu_x = '0; lcu_y = '0; lcu_size = '0;
        t_en = 1'b0; t_din = '0; t_x = '0; t_y = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_wen", int'(sram_wen), 0);
        check("rst_addr", int'(sram_addr), 0);
        check("rst_d", int'(sram_d), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Band offset, window wrapping past band 31
        fill(100);
        pix[0] = 240; pix[1] = 250; pix[2] = 0; pix[3] = 10; pix[4] = 100;
        base = wr_total;
        send_lcu(16, 1, 30, 0, 'h87E3, 0, 0, 0, 1'b0, 0, bc);
        repeat (2) @(negedge clk);
        check("bo_cnt", wr_total - base, 256);
        check("bo_addr0", addr_log[base], 0);
        for (int i = 0; i < 5; i++) check("bo_pix", dat_log[base + i], bo_exp[i]);

        // Band offset clipping at both ends
        fill(100);
        pix[0] = 255; pix[1] = 3;
        base = wr_total;
        send_lcu(16, 1, 29, 0, 'h87E3, 1, 0, 0, 1'b0, 0, bc);
        repeat (2) @(negedge clk);
        check("bo2_addr0", addr_log[base], 16);
        check("bo2_hi", dat_log[base], 255);
        check("bo2_lo", dat_log[base + 1], 0);

        // Horizontal EO with in_en held through the drain
        fill(10);
        pix[16] = 5; pix[19] = 5; pix[23] = 5; pix[24] = 5; pix[31] = 20;
        base = wr_total;
        send_lcu(16, 2, 0, 0, 'hEF12, 2, 1, 0, 1'b1, 0, bc);
        check("hs_busy", bc, 256);
        repeat (2) @(negedge clk);
        check("hs_cnt", wr_total - base, 256);
        check("hs_first", addr_log[base], 2080);
        check("hs_last", addr_log[base + 255], 4015);
        check("eo0_min", dat_log[base + 19], 7);
        check("eo0_half", dat_log[base + 24], 6);
        check("eo0_col0", dat_log[base + 16], 5);
        check("eo0_col15", dat_log[base + 31], 20);

        // Vertical EO
        fill(10);
        pix[5] = 30; pix[53] = 5; pix[96] = 5;
        base = wr_total;
        send_lcu(16, 2, 0, 1, 'hEF12, 3, 0, 0, 1'b0, 0, bc);
        repeat (2) @(negedge clk);
        check("eo1_row0", dat_log[base + 5], 30);
        check("eo1_min", dat_log[base + 53], 7);
        check("eo1_col0", dat_log[base + 96], 7);
        check("eo1_addr", addr_log[base + 96], 48 + 6 * 128);

        // 10-bit clip
        for (int i = 0; i < 256; i++) begin
            t_en  = 1'b1;
            t_din = (i == 0) ? 10'd1020 : (i == 1) ? 10'd1000 : (i == 2) ? 10'd40 : 10'd0;
            @(posedge clk); #1;
        end
        t_en = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("d10_cnt", t_wr, 256);
        check("d10_clip", t_log[0], 1023);
        check("d10_add", t_log[1], 1007);
        check("d10_keep", t_log[2], 40);

        // Full frame of 32x32 LCUs, filter off
        fbase = wr_total;
        for (int ly = 0; ly < 4; ly++) begin
            for (int lx = 0; lx < 4; lx++) begin
                for (int i = 0; i < 1024; i++)
                    pix[i] = ((i / 32) * 3 + (i % 32) + lx * 7 + ly * 11) & 255;
                send_lcu(32, 0, 0, 0, 0, lx, ly, 1, 1'b0, 0, bc);
                if (lx == 2 && ly == 3) check("fin_early", int'(finish), 0);
            end
        end
        check("fin_pre", int'(finish), 0);
        check("last_wen", int'(sram_wen), 1);
        check("last_addr", int'(sram_addr), 16383);
        @(negedge clk);
        check("fin_rise", int'(finish), 1);
        check("wen_off", int'(sram_wen), 0);
        repeat (10) @(negedge clk);
        check("fin_hold", int'(finish), 1);
        errs = 0; uniq = 0;
        for (int j = 0; j < 16384; j++) seen[j] = 1'b0;
        for (int j = 0; j < 16384; j++) begin
            a = addr_log[fbase + j];
            e = (((a / 128) % 32) * 3 + ((a % 128) % 32) + ((a % 128) / 32) * 7 + ((a / 128) / 32) * 11) & 255;
            if (dat_log[fbase + j] != e) errs++;
            if (!seen[a]) begin
                seen[a] = 1'b1;
                uniq++;
            end
        end
        check("frm_cnt", wr_total - fbase, 16384);
        check("frm_err", errs, 0);
        check("frm_uniq", uniq, 16384);

        // Reset during drain, then reload the same LCU
        fill(100);
        pix[0] = 240; pix[1] = 250; pix[2] = 0; pix[3] = 10; pix[4] = 100;
        send_lcu(16, 1, 30, 0, 'h87E3, 0, 0, 0, 1'b0, 100, bc);
        check("fin_clr", int'(finish), 0);
        check("mid_wen", int'(sram_wen), 1);
        reset = 1'b0;
        #1;
        check("abort_wen", int'(sram_wen), 0);
        check("abort_busy", int'(busy), 0);
        n0 = wr_total;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_nowr", wr_total, n0);
        base = wr_total;
        send_lcu(16, 1, 30, 0, 'h87E3, 0, 0, 0, 1'b0, 0, bc);
        repeat (2) @(negedge clk);
        check("rl_cnt", wr_total - base, 256);
        check("rl_addr0", addr_log[base], 0);
        for (int i = 0; i < 5; i++) check("rl_pix", dat_log[base + i], bo_exp[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
